and16_share_arbiter: RTL and testbench

- Shares one And16bit bitwise-AND unit among NUM_REQ requesters.
- Round-robin arbitration; operands latched into a holding register, AND computed, result returned with requester ID over a valid/ready response channel.
- Sits between instruction/test sequencers and the 16-bit logic datapath; the And16bit instance is internal.

---
 rtl/and16_share_arbiter.sv | 168 ++++++++++++++++
 tb/tb_and16_share_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/and16_share_arbiter.sv
// Round-robin arbiter sharing one 16-bit AND unit among NUM_REQ requesters.
// Optional AND16_ARB_OPCOUNT_EN adds a 16-bit completed-response counter output.
module And16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bit
            assign y[gi] = a[gi] & b[gi];
        end
    endgenerate
endmodule

module and16_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic [NUM_REQ-1:0]      reqValid,
    input  logic [16*NUM_REQ-1:0]   reqA,
    input  logic [16*NUM_REQ-1:0]   reqB,
    output logic [NUM_REQ-1:0]      reqReady,
    output logic                    respValid,
    output logic [15:0]             respData,
    output logic [ID_W-1:0]         respId,
    input  logic                    respReady,
`ifdef AND16_ARB_OPCOUNT_EN
    output logic [15:0]             opCount,
`endif
    output logic                    busy
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [15:0]       op_a_q, op_a_d;
    logic [15:0]       op_b_q, op_b_d;
    logic [15:0]       resp_data_q, resp_data_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;
    logic              resp_valid_q, resp_valid_d;
    logic              busy_q, busy_d;

    logic [15:0]       a_arr [NUM_REQ];
    logic [15:0]       b_arr [NUM_REQ];
    logic [15:0]       and_y;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W:0]     sum;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = reqA[16*gi +: 16];
            assign b_arr[gi] = reqB[16*gi +: 16];
        end
    endgenerate

    And16bit u_and (
        .a (op_a_q),
        .b (op_b_q),
        .y (and_y)
    );

    // Scan requesters starting at rr_ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_found && reqValid[sum[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        reqReady     = '0;
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        resp_valid_d = resp_valid_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    reqReady  = NUM_REQ'(1) << grant_idx;
                    op_a_d    = a_arr[grant_idx];
                    op_b_d    = b_arr[grant_idx];
                    resp_id_d = grant_idx;
                    rr_ptr_d  = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                resp_data_d  = and_y;
                resp_valid_d = 1'b1;
                state_d      = DONE;
            end
            DONE: begin
                if (respReady) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign respValid = resp_valid_q;
    assign respData  = resp_data_q;
    assign respId    = resp_id_q;
    assign busy      = busy_q;

`ifdef AND16_ARB_OPCOUNT_EN
    logic [15:0] op_count_q, op_count_d;

    // Counts accepted responses only; wraps naturally at 16 bits.
    always_comb begin
        op_count_d = op_count_q;
        if (state_q == DONE && respReady) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign opCount = op_count_q;
`endif
endmodule

// File: tb/tb_and16_share_arbiter.sv
// Bench for and16_share_arbiter: transaction-level model plus directed vectors.
module tb_and16_share_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rstN = 1'b0;
    logic [N-1:0]      reqValid = '0;
    logic [16*N-1:0]   reqA = '0;
    logic [16*N-1:0]   reqB = '0;
    logic              respReady = 1'b0;
    logic [N-1:0]      reqReady;
    logic              respValid;
    logic [15:0]       respData;
    logic [IW-1:0]     respId;
    logic              busy;
`ifdef AND16_ARB_OPCOUNT_EN
    logic [15:0]       opCount;
    logic [15:0]       cnt_bias = 16'h0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    and16_share_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .reqValid  (reqValid),
        .reqA      (reqA),
        .reqB      (reqB),
        .reqReady  (reqReady),
        .respValid (respValid),
        .respData  (respData),
        .respId    (respId),
        .respReady (respReady),
`ifdef AND16_ARB_OPCOUNT_EN
        .opCount   (opCount),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Next requester at or after ptr, otherwise the lowest one below it.
    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int i = ptr; i < N; i++) if (v[i[IW-1:0]]) return i;
        for (int i = 0; i < ptr; i++) if (v[i[IW-1:0]]) return i;
        return -1;
    endfunction

    function automatic logic [15:0] opnd(input logic [16*N-1:0] v, input int i);
        return v[16*i +: 16];
    endfunction

    // Transaction model: phase 0 idle, 1 computing, 2 holding the result.
    int          m_phase = 0;
    int          m_ptr   = 0;
    int          m_id    = 0;
    int          m_hs    = 0;
    logic        m_valid = 1'b0;
    logic [15:0] m_data  = 16'h0;
    logic [15:0] m_pend  = 16'h0;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            m_phase <= 0; m_ptr <= 0; m_id <= 0; m_hs <= 0;
            m_valid <= 1'b0; m_data <= 16'h0; m_pend <= 16'h0;
        end else begin
            case (m_phase)
                0: if (rr_pick(reqValid, m_ptr) >= 0) begin
                    m_pend  <= opnd(reqA, rr_pick(reqValid, m_ptr)) & opnd(reqB, rr_pick(reqValid, m_ptr));
                    m_id    <= rr_pick(reqValid, m_ptr);
                    m_ptr   <= (rr_pick(reqValid, m_ptr) + 1) % N;
                    m_phase <= 1;
                end
                1: begin m_data <= m_pend; m_valid <= 1'b1; m_phase <= 2; end
                default: if (respReady) begin m_valid <= 1'b0; m_phase <= 0; m_hs <= m_hs + 1; end
            endcase
        end
    end

    int          gq[$];
    int          rid[$];
    logic [15:0] rdat[$];

    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        int p;
        p = rr_pick(reqValid, m_ptr);
        exp_ready = (m_phase == 0 && p >= 0) ? N'(1) << p : '0;
        chk("reqReady", 32'(reqReady), 32'(exp_ready));
        chk("respValid", 32'(respValid), 32'(m_valid));
        chk("respData", 32'(respData), 32'(m_data));
        chk("respId", 32'(respId), 32'(m_id));
        chk("busy", 32'(busy), 32'(m_phase != 0));
`ifdef AND16_ARB_OPCOUNT_EN
        chk("opCount", 32'(opCount), 32'(16'(m_hs) + cnt_bias));
`endif
        for (int i = 0; i < N; i++) if (reqReady[i[IW-1:0]]) gq.push_back(i);
        if (respValid && respReady) begin
            rid.push_back(int'(respId));
            rdat.push_back(respData);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
    endtask

    initial begin
        int k;
        int nresp;
        int idx2;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int nresp;
        int idx2;
        repeat (2) tick();
        chk("rst_respValid", 32'(respValid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_respData", 32'(respData), 32'h0);
        rstN = 1'b1;
        tick();

        // Single request from requester 0
        reqA[15:0] = 16'h3CC3; reqB[15:0] = 16'h0FF0;
        reqValid = 4'b0001; respReady = 1'b1;
        #1 chk("t1_grant", 32'(reqReady), 32'h1);
        tick(); reqValid = '0;
        chk("t1_busy", 32'(busy), 32'h1);
        tick();
        chk("t1_valid", 32'(respValid), 32'h1);
        chk("t1_data", 32'(respData), 32'h0CC0);
        chk("t1_id", 32'(respId), 32'h0);
        tick();
        chk("t1_idle_valid", 32'(respValid), 32'h0);
        chk("t1_idle_busy", 32'(busy), 32'h0);

        // All requesters continuously valid
        do_reset();
        gq.delete(); rid.delete(); rdat.delete();
        reqA = {16'h8001, 16'h1234, 16'hF0F0, 16'hFFFF};
        reqB = {16'hFFFF, 16'h9876, 16'hAAAA, 16'h00FF};
        reqValid = 4'b1111; respReady = 1'b1;
        repeat (14) tick();
        reqValid = '0;
        repeat (4) tick();
        chk("t2_ngrants", 32'(gq.size() >= 5), 32'h1);
        if (gq.size() >= 5) begin
            chk("t2_g0", 32'(gq[0]), 32'd0);
            chk("t2_g1", 32'(gq[1]), 32'd1);
            chk("t2_g2", 32'(gq[2]), 32'd2);
            chk("t2_g3", 32'(gq[3]), 32'd3);
            chk("t2_g4", 32'(gq[4]), 32'd0);
        end
        idx2 = -1;
        for (int i = 0; i < rid.size(); i++) if (rid[i] == 2 && idx2 < 0) idx2 = i;
        chk("t2_req2_seen", 32'(idx2 >= 0), 32'h1);
        if (idx2 >= 0) chk("t2_req2_data", 32'(rdat[idx2]), 32'h1034);

        // Backpressure on requester 1
        respReady = 1'b0; reqValid = 4'b0010;
        k = 0;
        while (!respValid && k < 10) begin tick(); k++; end
        chk("t3_valid_seen", 32'(respValid), 32'h1);
        reqValid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t3_hold_valid", 32'(respValid), 32'h1);
            chk("t3_hold_data", 32'(respData), 32'hA0A0);
            chk("t3_hold_id", 32'(respId), 32'h1);
            chk("t3_hold_ready", 32'(reqReady), 32'h0);
        end
        nresp = rid.size();
        respReady = 1'b1; reqValid = '0;
        tick();
        chk("t3_released", 32'(respValid), 32'h0);
        tick();
        chk("t3_one_hs", 32'(rid.size() - nresp), 32'd1);

        // Round-robin skip from pointer 1
        do_reset();
        reqValid = 4'b0001;
        tick(); reqValid = '0;
        repeat (2) tick();
        gq.delete();
        reqValid = 4'b1001;
        k = 0;
        while (gq.size() < 2 && k < 12) begin tick(); k++; end
        reqValid = '0;
        repeat (3) tick();
        chk("t4_ngrants", 32'(gq.size()), 32'd2);
        if (gq.size() >= 2) begin
            chk("t4_first", 32'(gq[0]), 32'd3);
            chk("t4_second", 32'(gq[1]), 32'd0);
        end

        // Asynchronous reset while computing
        reqValid = 4'b0100;
        tick(); reqValid = '0;
        chk("t5_in_exec", 32'(busy), 32'h1);
        nresp = rid.size();
        #1 rstN = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(respValid), 32'h0);
        chk("t5_rst_busy", 32'(busy), 32'h0);
        chk("t5_rst_ptr", 32'(dut.rr_ptr_q), 32'h0);
        tick();
        rstN = 1'b1;
        repeat (5) tick();
        chk("t5_no_resp", 32'(rid.size() - nresp), 32'd0);
        chk("t5_valid_low", 32'(respValid), 32'h0);

`ifdef AND16_ARB_OPCOUNT_EN
        force dut.op_count_q = 16'hFFFE;
        cnt_bias = 16'hFFFE - 16'(m_hs);
        #1 release dut.op_count_q;
        tick();
        chk("t6_preload", 32'(opCount), 32'hFFFE);
        reqValid = 4'b0001; respReady = 1'b1;
        nresp = rid.size();
        k = 0;
        while (rid.size() - nresp < 2 && k < 20) begin tick(); k++; end
        reqValid = '0;
        repeat (4) tick();
        chk("t6_wrap", 32'(opCount), 32'h0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
